// File: rtl/vision_pkg.sv
// Shared types and constants for the grayscale vision pipeline stages.
package vision_pkg;

  localparam int unsigned GS_W           = 8;
  localparam int unsigned WIN_W          = 72;
  localparam int unsigned IMG_WIDTH_DEF  = 640;
  localparam int unsigned IMG_HEIGHT_DEF = 480;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } win_state_t;

endpackage

// File: rtl/gs_line_buffer.sv
// Single-address line buffer: the read returns the contents before this cycle's write.
module gs_line_buffer
  import vision_pkg::*;
#(
  parameter int unsigned DEPTH = IMG_WIDTH_DEF,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_addr,
  input  logic [GS_W-1:0] i_wdata,
  output logic [GS_W-1:0] o_rdata
);

  logic [GS_W-1:0] r_mem [DEPTH];

  // Read data is captured by the caller on the same edge that writes, so it sees old contents.
  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/gs_window_3x3.sv
// Sliding 3x3 neighbourhood generator over a raster grayscale stream with frame tracking.
module gs_window_3x3
  import vision_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [GS_W-1:0]  point_input,
  input  logic             input_en,
  input  logic             frame_start,
  output logic [WIN_W-1:0] window_out,
  output logic             output_valid,
  output logic             frame_done,
  output logic             frame_overrun
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);

  win_state_t      r_state, w_state_nxt;
  logic [CW-1:0]   r_col, w_col;
  logic [RW-1:0]   r_row, w_row;
  logic            w_start, w_proc, w_eol, w_last;
  logic [GS_W-1:0] w_lb1_rd, w_lb2_rd;
  logic [GS_W-1:0] r_win [9];
  logic            r_valid, r_overrun;

  assign w_start = input_en & frame_start;
  assign w_proc  = input_en & (frame_start | (r_state == ST_ACTIVE));
  assign w_col   = w_start ? '0 : r_col;
  assign w_row   = w_start ? '0 : r_row;
  assign w_eol   = (w_col == CW'(IMG_WIDTH - 1));
  assign w_last  = w_eol && (w_row == RW'(IMG_HEIGHT - 1));

  gs_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk     (clk),
    .i_we    (w_proc),
    .i_addr  (w_col),
    .i_wdata (point_input),
    .o_rdata (w_lb1_rd)
  );

  gs_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb2 (
    .clk     (clk),
    .i_we    (w_proc),
    .i_addr  (w_col),
    .i_wdata (w_lb1_rd),
    .o_rdata (w_lb2_rd)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_proc)                 w_state_nxt = w_last ? ST_DONE : ST_ACTIVE;
    else if (r_state == ST_DONE) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_proc && (w_row >= RW'(2)) && (w_col >= CW'(2));
      if (w_start)       r_overrun <= 1'b0;
      else if (input_en && !w_proc) r_overrun <= 1'b1;
      if (w_proc) begin
        r_row <= w_row;
        if (w_eol) begin
          r_col <= '0;
          r_row <= w_last ? '0 : w_row + RW'(1);
        end else begin
          r_col <= w_col + CW'(1);
        end
      end
    end
  end

  // Row 0 of the window is the oldest line (LB2), row 2 the incoming pixel's line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 9; k++) r_win[k] <= '0;
    end else if (w_proc) begin
      for (int unsigned i = 0; i < 3; i++) begin
        r_win[3*i]   <= r_win[3*i+1];
        r_win[3*i+1] <= r_win[3*i+2];
      end
      r_win[2] <= w_lb2_rd;
      r_win[5] <= w_lb1_rd;
      r_win[8] <= point_input;
    end
  end

  always_comb begin
    window_out = '0;
    for (int unsigned k = 0; k < 9; k++) window_out[8*(8-k) +: 8] = r_win[k];
  end

  assign output_valid  = r_valid;
  assign frame_done    = (r_state == ST_DONE);
  assign frame_overrun = r_overrun;

endmodule
